// File: rtl/pacman_pkg.sv
// Shared types and tile-geometry helpers for the Pac-Man movement controller.
package pacman_pkg;

  localparam int unsigned TILE_W = 5;

  // Encoding matches constants.vh
  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_Q_REQ,
    S_Q_CUR,
    S_STEP
  } mv_state_t;

  typedef struct packed {
    logic [TILE_W-1:0] x;
    logic [TILE_W-1:0] y;
    logic              oob;
  } nbr_t;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    r = LEFT;
    case (d)
      LEFT:  r = RIGHT;
      RIGHT: r = LEFT;
      UP:    r = DOWN;
      DOWN:  r = UP;
      default: r = LEFT;
    endcase
    return r;
  endfunction

  // x wraps through the tunnel; y has no wrap, so leaving the grid flags oob
  function automatic nbr_t neighbour(input logic [TILE_W-1:0] x,
                                     input logic [TILE_W-1:0] y,
                                     input dir_t              d,
                                     input int unsigned       grid_w,
                                     input int unsigned       grid_h);
    nbr_t n;
    n.x   = x;
    n.y   = y;
    n.oob = 1'b0;
    case (d)
      LEFT:  n.x = (x == '0) ? TILE_W'(grid_w - 1) : x - TILE_W'(1);
      RIGHT: n.x = (x == TILE_W'(grid_w - 1)) ? '0 : x + TILE_W'(1);
      UP: begin
        if (y == '0) n.oob = 1'b1;
        else         n.y = y - TILE_W'(1);
      end
      DOWN: begin
        if (y == TILE_W'(grid_h - 1)) n.oob = 1'b1;
        else                          n.y = y + TILE_W'(1);
      end
      default: n.oob = 1'b1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wall_query.sv
// Wall-memory query port: holds req/x/y until valid, then presents a one-cycle
// registered done with the captured is_wall bit. Abort drops any open query.
module wall_query
  import pacman_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_abort,
  input  logic              i_start,
  input  logic [TILE_W-1:0] i_x,
  input  logic [TILE_W-1:0] i_y,
  input  logic              i_valid,
  input  logic              i_is_wall,
  output logic              o_req,
  output logic [TILE_W-1:0] o_x,
  output logic [TILE_W-1:0] o_y,
  output logic              o_done,
  output logic              o_is_wall
);

  logic              r_req;
  logic [TILE_W-1:0] r_x;
  logic [TILE_W-1:0] r_y;
  logic              r_done;
  logic              r_is_wall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req     <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_done    <= 1'b0;
      r_is_wall <= 1'b0;
    end else if (i_abort) begin
      r_req  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // valid without an open request is ignored
      if (r_req && i_valid) begin
        r_req     <= 1'b0;
        r_done    <= 1'b1;
        r_is_wall <= i_is_wall;
      end else if (i_start) begin
        r_req <= 1'b1;
        r_x   <= i_x;
        r_y   <= i_y;
      end
    end
  end

  assign o_req     = r_req;
  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_done    = r_done;
  assign o_is_wall = r_is_wall;

endmodule

// File: rtl/pacman_move_ctrl.sv
// Pac-Man tile-step controller: tries the requested turn, falls back to the current
// heading, then steps one tile. Optional macro: PACMAN_REVERSE_FAST_EN (query-free reversal).
module pacman_move_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned GRID_W  = 28,
  parameter int unsigned GRID_H  = 31,
  parameter int unsigned START_X = 13,
  parameter int unsigned START_Y = 23
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              game_started,
  input  logic              lost_life,
  input  logic [1:0]        req_dir,
  input  logic              move_tick,
  output logic              wall_rd_req,
  output logic [TILE_W-1:0] wall_rd_x,
  output logic [TILE_W-1:0] wall_rd_y,
  input  logic              wall_rd_valid,
  input  logic              wall_rd_is_wall,
  output logic [TILE_W-1:0] tile_x,
  output logic [TILE_W-1:0] tile_y,
  output logic [1:0]        cur_dir,
  output logic              moved
);

  mv_state_t         r_state, w_next;
  dir_t              r_cur_dir, r_qdir, w_req_dir, w_new_dir;
  logic [TILE_W-1:0] r_tile_x, r_tile_y;
  logic              r_pending, r_moved;
  logic              w_go, w_start, w_step, w_set_dir, w_latch_qdir;
  logic [TILE_W-1:0] w_qx, w_qy;
  logic              w_done, w_is_wall;
  nbr_t              w_n_req, w_n_cur;

  assign w_req_dir = dir_t'(req_dir);
  assign w_n_req   = neighbour(r_tile_x, r_tile_y, w_req_dir, GRID_W, GRID_H);
  assign w_n_cur   = neighbour(r_tile_x, r_tile_y, r_cur_dir, GRID_W, GRID_H);
  assign w_go      = (move_tick | r_pending) & game_started;

  wall_query u_wall_query (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_abort   (lost_life),
    .i_start   (w_start),
    .i_x       (w_qx),
    .i_y       (w_qy),
    .i_valid   (wall_rd_valid),
    .i_is_wall (wall_rd_is_wall),
    .o_req     (wall_rd_req),
    .o_x       (wall_rd_x),
    .o_y       (wall_rd_y),
    .o_done    (w_done),
    .o_is_wall (w_is_wall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_state <= S_IDLE;
    else if (lost_life) r_state <= S_IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_qx         = w_n_cur.x;
    w_qy         = w_n_cur.y;
    w_step       = 1'b0;
    w_set_dir    = 1'b0;
    w_new_dir    = r_qdir;
    w_latch_qdir = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
`ifdef PACMAN_REVERSE_FAST_EN
          if (w_req_dir == opposite(r_cur_dir)) begin
            w_next    = S_STEP;
            w_set_dir = 1'b1;
            w_new_dir = w_req_dir;
          end else
`endif
          // an out-of-range turn counts as a wall and falls straight back to the heading
          if (w_req_dir != r_cur_dir && !w_n_req.oob) begin
            w_next       = S_Q_REQ;
            w_start      = 1'b1;
            w_qx         = w_n_req.x;
            w_qy         = w_n_req.y;
            w_latch_qdir = 1'b1;
          end else if (!w_n_cur.oob) begin
            w_next  = S_Q_CUR;
            w_start = 1'b1;
          end
        end
      end
      S_Q_REQ: begin
        if (w_done) begin
          if (!w_is_wall) begin
            w_next    = S_STEP;
            w_set_dir = 1'b1;
          end else if (!w_n_cur.oob) begin
            w_next  = S_Q_CUR;
            w_start = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_Q_CUR: begin
        if (w_done) w_next = w_is_wall ? S_IDLE : S_STEP;
      end
      S_STEP: begin
        w_step = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tile_x  <= TILE_W'(START_X);
      r_tile_y  <= TILE_W'(START_Y);
      r_cur_dir <= LEFT;
      r_qdir    <= LEFT;
      r_pending <= 1'b0;
      r_moved   <= 1'b0;
    end else if (lost_life) begin
      r_tile_x  <= TILE_W'(START_X);
      r_tile_y  <= TILE_W'(START_Y);
      r_cur_dir <= LEFT;
      r_pending <= 1'b0;
      r_moved   <= 1'b0;
    end else begin
      r_moved <= w_step;
      if (w_step) begin
        r_tile_x <= w_n_cur.x;
        r_tile_y <= w_n_cur.y;
      end
      if (w_set_dir)    r_cur_dir <= w_new_dir;
      if (w_latch_qdir) r_qdir    <= w_req_dir;
      // IDLE consumes the pending tick whether or not a query is launched
      if (!game_started || r_state == S_IDLE) r_pending <= 1'b0;
      else if (move_tick)                     r_pending <= 1'b1;
    end
  end

  assign tile_x  = r_tile_x;
  assign tile_y  = r_tile_y;
  assign cur_dir = r_cur_dir;
  assign moved   = r_moved;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Scoreboard bench for pacman_move_ctrl: expected wall queries and tile moves are
// queued as stimulus is applied and popped by the responder/move monitor.
module tb_pacman_move_ctrl;
  import pacman_pkg::*;

  localparam int unsigned RD_LAT = 2;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] d;
  } mv_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       game_started;
  logic       lost_life;
  logic [1:0] req_dir;
  logic       move_tick;
  logic       wall_rd_req;
  logic [4:0] wall_rd_x, wall_rd_y;
  logic       wall_rd_valid;
  logic       wall_rd_is_wall;
  logic [4:0] tile_x, tile_y;
  logic [1:0] cur_dir;
  logic       moved;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_q[$];
  mv_t        exp_m[$];
  logic       wall_map[0:31][0:31];
  logic       rsp_hold   = 1'b0;
  logic       late_valid = 1'b0;

  always #5 clk = ~clk;

  pacman_move_ctrl #(
    .GRID_W (28),
    .GRID_H (31),
    .START_X(13),
    .START_Y(23)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .game_started   (game_started),
    .lost_life      (lost_life),
    .req_dir        (req_dir),
    .move_tick      (move_tick),
    .wall_rd_req    (wall_rd_req),
    .wall_rd_x      (wall_rd_x),
    .wall_rd_y      (wall_rd_y),
    .wall_rd_valid  (wall_rd_valid),
    .wall_rd_is_wall(wall_rd_is_wall),
    .tile_x         (tile_x),
    .tile_y         (tile_y),
    .cur_dir        (cur_dir),
    .moved          (moved)
  );

  // Wall memory model: answers each new request RD_LAT cycles after it rises
  initial begin : responder
    int         cnt;
    logic       busy;
    logic [9:0] e;
    cnt = 0;
    busy = 1'b0;
    wall_rd_valid = 1'b0;
    wall_rd_is_wall = 1'b0;
    forever begin
      @(negedge clk);
      wall_rd_valid = 1'b0;
      if (wall_rd_req === 1'b1) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL query_unexpected got (%0d,%0d) expected none", wall_rd_x, wall_rd_y);
          end else begin
            e = exp_q.pop_front();
            if ({wall_rd_x, wall_rd_y} !== e) begin
              n_errors++;
              $display("FAIL query_addr got (%0d,%0d) expected (%0d,%0d)",
                       wall_rd_x, wall_rd_y, e[9:5], e[4:0]);
            end
          end
        end
        cnt++;
        if (cnt >= RD_LAT && !rsp_hold) begin
          wall_rd_valid = 1'b1;
          wall_rd_is_wall = wall_map[wall_rd_x][wall_rd_y];
          busy = 1'b0;
        end
      end else begin
        busy = 1'b0;
      end
      if (late_valid) begin
        wall_rd_valid = 1'b1;
        wall_rd_is_wall = 1'b0;
        late_valid = 1'b0;
      end
    end
  end

  initial begin : move_monitor
    mv_t m;
    forever begin
      @(negedge clk);
      if (moved === 1'b1) begin
        n_checks++;
        if (exp_m.size() == 0) begin
          n_errors++;
          $display("FAIL move_unexpected got (%0d,%0d,dir %0d) expected none", tile_x, tile_y, cur_dir);
        end else begin
          m = exp_m.pop_front();
          if ({tile_x, tile_y, cur_dir} !== m) begin
            n_errors++;
            $display("FAIL move got (%0d,%0d,dir %0d) expected (%0d,%0d,dir %0d)",
                     tile_x, tile_y, cur_dir, m.x, m.y, m.d);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push_q(input int x, input int y);
    exp_q.push_back({5'(x), 5'(y)});
  endtask

  task automatic push_m(input int x, input int y, input dir_t d);
    mv_t m;
    m.x = 5'(x);
    m.y = 5'(y);
    m.d = d;
    exp_m.push_back(m);
  endtask

  task automatic tick_wait(input int n);
    @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    game_started = 1'b0;
    lost_life = 1'b0;
    move_tick = 1'b0;
    req_dir = LEFT;
    rsp_hold = 1'b0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        wall_map[i][j] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (tile_x !== 5'd13) begin n_errors++; $display("FAIL reset_tile_x got %0d expected 13", tile_x); end
    n_checks++;
    if (tile_y !== 5'd23) begin n_errors++; $display("FAIL reset_tile_y got %0d expected 23", tile_y); end
    n_checks++;
    if (cur_dir !== LEFT) begin n_errors++; $display("FAIL reset_cur_dir got %0d expected 0", cur_dir); end
    n_checks++;
    if (moved !== 1'b0) begin n_errors++; $display("FAIL reset_moved got %b expected 0", moved); end
    n_checks++;
    if (wall_rd_req !== 1'b0) begin n_errors++; $display("FAIL reset_req got %b expected 0", wall_rd_req); end
  endtask

  task automatic test_straight();
    int lat;
    do_reset();
    game_started = 1'b1;
    req_dir = LEFT;
    push_q(12, 23);
    push_m(12, 23, LEFT);
    @(negedge clk);
    move_tick = 1'b1;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      move_tick = 1'b0;
      if (moved === 1'b1) begin
        lat = c;
        break;
      end
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (lat != 1 + RD_LAT + 1) begin
      n_errors++;
      $display("FAIL straight_latency got %0d expected %0d", lat, 1 + RD_LAT + 1);
    end
    n_checks++;
    if (tile_x !== 5'd12) begin n_errors++; $display("FAIL straight_tile_x got %0d expected 12", tile_x); end
    n_checks++;
    if (exp_q.size() != 0 || exp_m.size() != 0) begin
      n_errors++;
      $display("FAIL straight_drain got q=%0d m=%0d expected 0", exp_q.size(), exp_m.size());
    end
  endtask

  task automatic test_turn_blocked();
    do_reset();
    game_started = 1'b1;
    wall_map[13][22] = 1'b1;
    req_dir = UP;
    push_q(13, 22);
    push_q(12, 23);
    push_m(12, 23, LEFT);
    tick_wait(14);
    n_checks++;
    if (cur_dir !== LEFT) begin n_errors++; $display("FAIL turn_cur_dir got %0d expected 0", cur_dir); end
    n_checks++;
    if (tile_x !== 5'd12) begin n_errors++; $display("FAIL turn_tile_x got %0d expected 12", tile_x); end
    n_checks++;
    if (exp_q.size() != 0 || exp_m.size() != 0) begin
      n_errors++;
      $display("FAIL turn_drain got q=%0d m=%0d expected 0", exp_q.size(), exp_m.size());
    end
  endtask

  task automatic test_both_walls();
    do_reset();
    game_started = 1'b1;
    wall_map[13][22] = 1'b1;
    wall_map[12][23] = 1'b1;
    req_dir = UP;
    push_q(13, 22);
    push_q(12, 23);
    tick_wait(14);
    n_checks++;
    if ({tile_x, tile_y} !== {5'd13, 5'd23}) begin
      n_errors++;
      $display("FAIL blocked_tile got (%0d,%0d) expected (13,23)", tile_x, tile_y);
    end
    n_checks++;
    if (cur_dir !== LEFT) begin n_errors++; $display("FAIL blocked_cur_dir got %0d expected 0", cur_dir); end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL blocked_drain got q=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int x, y;
    do_reset();
    game_started = 1'b1;
    req_dir = LEFT;
    x = 13;
    y = 23;
    for (int i = 0; i < 14; i++) begin
      x = (x == 0) ? 27 : x - 1;
      push_q(x, y);
      push_m(x, y, LEFT);
      tick_wait(10);
    end
    n_checks++;
    if (tile_x !== 5'd27) begin n_errors++; $display("FAIL wrap_tile_x got %0d expected 27", tile_x); end
    req_dir = UP;
    for (int i = 0; i < 23; i++) begin
      y = y - 1;
      push_q(x, y);
      push_m(x, y, UP);
      tick_wait(10);
    end
    tick_wait(10);
    n_checks++;
    if ({tile_x, tile_y} !== {5'd27, 5'd0}) begin
      n_errors++;
      $display("FAIL top_edge_tile got (%0d,%0d) expected (27,0)", tile_x, tile_y);
    end
    req_dir = LEFT;
    push_q(26, 0);
    push_m(26, 0, LEFT);
    tick_wait(10);
    req_dir = UP;
    push_q(25, 0);
    push_m(25, 0, LEFT);
    tick_wait(10);
    n_checks++;
    if ({tile_x, tile_y} !== {5'd25, 5'd0}) begin
      n_errors++;
      $display("FAIL oob_fallback_tile got (%0d,%0d) expected (25,0)", tile_x, tile_y);
    end
    n_checks++;
    if (exp_q.size() != 0 || exp_m.size() != 0) begin
      n_errors++;
      $display("FAIL wrap_drain got q=%0d m=%0d expected 0", exp_q.size(), exp_m.size());
    end
  endtask

  task automatic test_reverse();
    do_reset();
    game_started = 1'b1;
    req_dir = RIGHT;
`ifndef PACMAN_REVERSE_FAST_EN
    push_q(14, 23);
`endif
    push_m(14, 23, RIGHT);
    tick_wait(10);
    n_checks++;
    if (cur_dir !== RIGHT) begin n_errors++; $display("FAIL reverse_cur_dir got %0d expected 1", cur_dir); end
    n_checks++;
    if (exp_q.size() != 0 || exp_m.size() != 0) begin
      n_errors++;
      $display("FAIL reverse_drain got q=%0d m=%0d expected 0", exp_q.size(), exp_m.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    game_started = 1'b1;
    req_dir = LEFT;
    push_q(12, 23);
    push_m(12, 23, LEFT);
    push_q(11, 23);
    push_m(11, 23, LEFT);
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (tile_x !== 5'd11) begin n_errors++; $display("FAIL pending_tile_x got %0d expected 11", tile_x); end
    n_checks++;
    if (exp_q.size() != 0 || exp_m.size() != 0) begin
      n_errors++;
      $display("FAIL pending_drain got q=%0d m=%0d expected 0", exp_q.size(), exp_m.size());
    end
  endtask

  task automatic test_game_stopped();
    game_started = 1'b0;
    tick_wait(10);
    n_checks++;
    if (tile_x !== 5'd11) begin n_errors++; $display("FAIL stopped_tile_x got %0d expected 11", tile_x); end
    push_q(10, 23);
    push_m(10, 23, LEFT);
    @(negedge clk); game_started = 1'b1; move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0; game_started = 1'b0;
    repeat (15) @(negedge clk);
    game_started = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (tile_x !== 5'd10) begin n_errors++; $display("FAIL inflight_tile_x got %0d expected 10", tile_x); end
    n_checks++;
    if (exp_q.size() != 0 || exp_m.size() != 0) begin
      n_errors++;
      $display("FAIL stopped_drain got q=%0d m=%0d expected 0", exp_q.size(), exp_m.size());
    end
  endtask

  task automatic test_lost_life();
    bit seen;
    do_reset();
    game_started = 1'b1;
    req_dir = LEFT;
    push_q(12, 23);
    push_m(12, 23, LEFT);
    tick_wait(10);
    rsp_hold = 1'b1;
    push_q(11, 23);
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (wall_rd_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL abort_req_rise got 0 expected 1"); end
    repeat (2) @(negedge clk);
    lost_life = 1'b1;
    @(negedge clk);
    lost_life = 1'b0;
    n_checks++;
    if (wall_rd_req !== 1'b0) begin n_errors++; $display("FAIL abort_req got %b expected 0", wall_rd_req); end
    n_checks++;
    if ({tile_x, tile_y} !== {5'd13, 5'd23}) begin
      n_errors++;
      $display("FAIL abort_tile got (%0d,%0d) expected (13,23)", tile_x, tile_y);
    end
    n_checks++;
    if (cur_dir !== LEFT) begin n_errors++; $display("FAIL abort_cur_dir got %0d expected 0", cur_dir); end
    late_valid = 1'b1;
    repeat (3) @(negedge clk);
    rsp_hold = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({wall_rd_req, tile_x, tile_y} !== {1'b0, 5'd13, 5'd23}) begin
      n_errors++;
      $display("FAIL late_valid got req=%b (%0d,%0d) expected req=0 (13,23)", wall_rd_req, tile_x, tile_y);
    end
    n_checks++;
    if (exp_q.size() != 0 || exp_m.size() != 0) begin
      n_errors++;
      $display("FAIL abort_drain got q=%0d m=%0d expected 0", exp_q.size(), exp_m.size());
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_turn_blocked();
    test_both_walls();
    test_wrap();
    test_reverse();
    test_back_to_back();
    test_game_stopped();
    test_lost_life();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
